givens_sequencer: RTL and testbench

- Sequences one shared CORDIC vector/rotate engine for Givens-rotation jobs in the QR datapath.
- The first (x,y) pair of each job runs in VECTOR mode, and the controller captures the per-iteration direction bits the engine emits.
- Every later pair of the same job runs in ROTATE mode, with the stored direction bits replayed in iteration order.
- Upstream and downstream use valid/ready handshakes; one pair is in flight at a time.

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/givens_sequencer_if.sv | 30 +++
 rtl/givens_dir_store.sv | 47 ++++
 rtl/givens_sequencer.sv | 153 +++++++++++++++
 tb/tb_givens_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and controller state encoding for the Givens-rotation
// CORDIC sequencer and its direction-bit store.
package cordic_pkg;

  localparam int BITWIDTH   = 18;
  localparam int CORDIC_NUM = 14;
  localparam int CNT_W      = 4;

  localparam logic VECTOR = 1'b0;
  localparam logic ROTATE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    WAIT_FIN,
    OUT
  } seq_state_e;

endpackage

// File: rtl/givens_sequencer_if.sv
// Upstream pair stream and downstream result stream of the Givens sequencer.
// The sequencer sits on the slave side; the producer/consumer on the master side.
interface givens_sequencer_if;
  import cordic_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [BITWIDTH-1:0]   in_x;
  logic [BITWIDTH-1:0]   in_y;
  logic                  in_last;

  logic                  out_valid;
  logic                  out_ready;
  logic [BITWIDTH-1:0]   out_x;
  logic [BITWIDTH-1:0]   out_y;
  logic                  out_vec;
  logic                  out_last;
  logic [CORDIC_NUM-1:0] out_dir;

  modport master (
    output in_valid, in_x, in_y, in_last, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_vec, out_last, out_dir
  );

  modport slave (
    input  in_valid, in_x, in_y, in_last, out_ready,
    output in_ready, out_valid, out_x, out_y, out_vec, out_last, out_dir
  );

endinterface

// File: rtl/givens_dir_store.sv
// Per-job CORDIC direction bits: captured one per iteration on a vectoring run,
// replayed in the same iteration order on rotate runs.
module givens_dir_store #(
  parameter int CORDIC_NUM = cordic_pkg::CORDIC_NUM,
  parameter int CNT_W      = cordic_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_i,
  input  logic                  mode_i,
  input  logic [CNT_W-1:0]      idx_i,
  input  logic                  d_i,
  output logic [CORDIC_NUM-1:0] dir_o,
  output logic                  d_o
);
  import cordic_pkg::*;

  logic [CORDIC_NUM-1:0] dir_q;
  logic [CORDIC_NUM-1:0] dir_d;
  logic                  rd_bit;

  // Only vectoring runs may overwrite the stored bits; rotate runs just read them.
  always_comb begin
    dir_d  = dir_q;
    rd_bit = 1'b0;
    for (int i = 0; i < CORDIC_NUM; i++) begin
      if (idx_i == CNT_W'(i)) begin
        rd_bit = dir_q[i];
        if (run_i && (mode_i == VECTOR)) begin
          dir_d[i] = d_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= '0;
    end else begin
      dir_q <= dir_d;
    end
  end

  assign d_o   = run_i && (mode_i == ROTATE) && rd_bit;
  assign dir_o = dir_q;

endmodule

// File: rtl/givens_sequencer.sv
// Sequences one shared CORDIC engine for Givens-rotation jobs: the first pair of
// a job vectors and records direction bits, later pairs rotate by replaying them.
module givens_sequencer #(
  parameter int BITWIDTH   = cordic_pkg::BITWIDTH,
  parameter int CORDIC_NUM = cordic_pkg::CORDIC_NUM,
  parameter int CNT_W      = cordic_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  givens_sequencer_if.slave   s_if,
  output logic                busy,
  output logic                cor_start_o,
  output logic                cor_mode_o,
  output logic [BITWIDTH-1:0] cor_x_o,
  output logic [BITWIDTH-1:0] cor_y_o,
  output logic                cor_d_o,
  input  logic [BITWIDTH-1:0] cor_x_i,
  input  logic [BITWIDTH-1:0] cor_y_i,
  input  logic                cor_d_i,
  input  logic                cor_finish_i
);
  import cordic_pkg::*;

  seq_state_e            state_q, state_d;
  logic [BITWIDTH-1:0]   x_q, x_d;
  logic [BITWIDTH-1:0]   y_q, y_d;
  logic                  last_q, last_d;
  logic                  mode_q, mode_d;
  logic                  job_open_q, job_open_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BITWIDTH-1:0]   out_x_q, out_x_d;
  logic [BITWIDTH-1:0]   out_y_q, out_y_d;
  logic                  out_vec_q, out_vec_d;
  logic                  out_last_q, out_last_d;
  logic                  run;
  logic [CORDIC_NUM-1:0] dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      last_q     <= 1'b0;
      mode_q     <= VECTOR;
      job_open_q <= 1'b0;
      cnt_q      <= '0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      out_vec_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      last_q     <= last_d;
      mode_q     <= mode_d;
      job_open_q <= job_open_d;
      cnt_q      <= cnt_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      out_vec_q  <= out_vec_d;
      out_last_q <= out_last_d;
    end
  end

  // A job stays open from its vectoring pair until a pair flagged last is
  // handed downstream; while open, every new pair rotates.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    last_d     = last_q;
    mode_d     = mode_q;
    job_open_d = job_open_q;
    cnt_d      = cnt_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    out_vec_d  = out_vec_q;
    out_last_d = out_last_q;

    case (state_q)
      IDLE: begin
        if (s_if.in_valid) begin
          x_d     = s_if.in_x;
          y_d     = s_if.in_y;
          last_d  = s_if.in_last;
          mode_d  = job_open_q ? ROTATE : VECTOR;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == CNT_W'(CORDIC_NUM - 1)) begin
          state_d = WAIT_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_FIN: begin
        if (cor_finish_i) begin
          out_x_d    = cor_x_i;
          out_y_d    = cor_y_i;
          out_vec_d  = (mode_q == VECTOR);
          out_last_d = last_q;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (s_if.out_ready) begin
          job_open_d = !out_last_q;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign run = (state_q == RUN);

  givens_dir_store #(
    .CORDIC_NUM (CORDIC_NUM),
    .CNT_W      (CNT_W)
  ) u_dir_store (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (run),
    .mode_i (mode_q),
    .idx_i  (cnt_q),
    .d_i    (cor_d_i),
    .dir_o  (dir),
    .d_o    (cor_d_o)
  );

  assign s_if.in_ready  = (state_q == IDLE);
  assign s_if.out_valid = (state_q == OUT);
  assign s_if.out_x     = out_x_q;
  assign s_if.out_y     = out_y_q;
  assign s_if.out_vec   = out_vec_q;
  assign s_if.out_last  = out_last_q;
  assign s_if.out_dir   = dir;

  assign busy        = (state_q != IDLE);
  assign cor_start_o = (state_q == LAUNCH);
  assign cor_mode_o  = mode_q;
  assign cor_x_o     = x_q;
  assign cor_y_o     = y_q;

endmodule

// File: tb/tb_givens_sequencer.sv
// Self-checking bench for givens_sequencer: emulates the CORDIC engine timing and
// predicts mode, replayed bits and results from a job-level model.
module tb_givens_sequencer;
  import cordic_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                busy;
  logic                cor_start_o;
  logic                cor_mode_o;
  logic [BITWIDTH-1:0] cor_x_o;
  logic [BITWIDTH-1:0] cor_y_o;
  logic                cor_d_o;
  logic [BITWIDTH-1:0] cor_x_i;
  logic [BITWIDTH-1:0] cor_y_i;
  logic                cor_d_i;
  logic                cor_finish_i;

  int total = 0;
  int bad   = 0;

  logic                  modelJobOpen;
  logic [CORDIC_NUM-1:0] modelDir;

  givens_sequencer_if bus();

  givens_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_if         (bus),
    .busy         (busy),
    .cor_start_o  (cor_start_o),
    .cor_mode_o   (cor_mode_o),
    .cor_x_o      (cor_x_o),
    .cor_y_o      (cor_y_o),
    .cor_d_o      (cor_d_o),
    .cor_x_i      (cor_x_i),
    .cor_y_i      (cor_y_i),
    .cor_d_i      (cor_d_i),
    .cor_finish_i (cor_finish_i)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'(0));
    checkOutput({tag, " out_x"}, 32'(bus.out_x), 32'(0));
    checkOutput({tag, " out_y"}, 32'(bus.out_y), 32'(0));
    checkOutput({tag, " out_vec"}, 32'(bus.out_vec), 32'(0));
    checkOutput({tag, " out_last"}, 32'(bus.out_last), 32'(0));
    checkOutput({tag, " out_dir"}, 32'(bus.out_dir), 32'(0));
    checkOutput({tag, " busy"}, 32'(busy), 32'(0));
    checkOutput({tag, " cor_start"}, 32'(cor_start_o), 32'(0));
    checkOutput({tag, " cor_d"}, 32'(cor_d_o), 32'(0));
  endtask

  // One pair end to end; the engine answers with random direction bits and results.
  task automatic applyStimulus(input logic [BITWIDTH-1:0] x, input logic [BITWIDTH-1:0] y,
                               input logic last, input int holdCycles,
                               input int spurAt, input int resetAt);
    logic                  expMode;
    logic [CORDIC_NUM-1:0] newDir;
    logic [BITWIDTH-1:0]   rx;
    logic [BITWIDTH-1:0]   ry;
    logic                  bitv;
    expMode = modelJobOpen ? ROTATE : VECTOR;
    newDir  = modelDir;
    rx      = BITWIDTH'($urandom);
    ry      = BITWIDTH'($urandom);

    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_last  = last;
    checkOutput("in_ready idle", 32'(bus.in_ready), 32'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_x     = BITWIDTH'($urandom);
    bus.in_y     = BITWIDTH'($urandom);
    checkOutput("start pulse", 32'(cor_start_o), 32'(1));
    checkOutput("start mode", 32'(cor_mode_o), 32'(expMode));
    checkOutput("start x", 32'(cor_x_o), 32'(x));
    checkOutput("start y", 32'(cor_y_o), 32'(y));
    checkOutput("busy launch", 32'(busy), 32'(1));
    checkOutput("in_ready launch", 32'(bus.in_ready), 32'(0));

    for (int i = 0; i < CORDIC_NUM; i++) begin
      @(posedge clk); #1;
      cor_finish_i = (i == spurAt);
      cor_x_i      = BITWIDTH'($urandom);
      bitv         = 1'($urandom);
      cor_d_i      = bitv;
      if (expMode == VECTOR) newDir[i] = bitv;
      checkOutput($sformatf("start low it%0d", i), 32'(cor_start_o), 32'(0));
      checkOutput($sformatf("cor_d it%0d", i), 32'(cor_d_o),
                  32'((expMode == ROTATE) ? modelDir[i] : 1'b0));
      checkOutput($sformatf("out_valid run it%0d", i), 32'(bus.out_valid), 32'(0));
      if (expMode == ROTATE) begin
        checkOutput($sformatf("out_dir stable it%0d", i), 32'(bus.out_dir), 32'(modelDir));
      end
      if (i == resetAt) begin
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid-run reset");
        cor_d_i      = 1'b0;
        cor_finish_i = 1'b0;
        @(posedge clk); #1;
        rst_n        = 1'b1;
        modelJobOpen = 1'b0;
        modelDir     = '0;
        return;
      end
    end

    @(posedge clk); #1;
    cor_d_i      = 1'b0;
    cor_finish_i = 1'b0;
    checkOutput("out_valid scaling", 32'(bus.out_valid), 32'(0));
    checkOutput("cor_d wait", 32'(cor_d_o), 32'(0));
    @(posedge clk); #1;
    cor_finish_i = 1'b1;
    cor_x_i      = rx;
    cor_y_i      = ry;
    checkOutput("out_valid at finish", 32'(bus.out_valid), 32'(0));
    @(posedge clk); #1;
    cor_finish_i = 1'b0;
    cor_x_i      = BITWIDTH'($urandom);
    cor_y_i      = BITWIDTH'($urandom);
    if (expMode == VECTOR) modelDir = newDir;
    checkOutput("out_valid", 32'(bus.out_valid), 32'(1));
    checkOutput("out_x", 32'(bus.out_x), 32'(rx));
    checkOutput("out_y", 32'(bus.out_y), 32'(ry));
    checkOutput("out_vec", 32'(bus.out_vec), 32'(expMode == VECTOR));
    checkOutput("out_last", 32'(bus.out_last), 32'(last));
    checkOutput("out_dir", 32'(bus.out_dir), 32'(modelDir));

    bus.out_ready = 1'b0;
    for (int k = 0; k < holdCycles; k++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput($sformatf("hold valid %0d", k), 32'(bus.out_valid), 32'(1));
      checkOutput($sformatf("hold x %0d", k), 32'(bus.out_x), 32'(rx));
      checkOutput($sformatf("hold y %0d", k), 32'(bus.out_y), 32'(ry));
      checkOutput($sformatf("hold in_ready %0d", k), 32'(bus.in_ready), 32'(0));
      checkOutput($sformatf("hold no start %0d", k), 32'(cor_start_o), 32'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    modelJobOpen  = !last;
    checkOutput("out_valid after xfer", 32'(bus.out_valid), 32'(0));
    checkOutput("busy after xfer", 32'(busy), 32'(0));
    checkOutput("in_ready after xfer", 32'(bus.in_ready), 32'(1));
  endtask

  initial begin
    int len;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    cor_x_i       = '0;
    cor_y_i       = '0;
    cor_d_i       = 1'b0;
    cor_finish_i  = 1'b0;
    modelJobOpen  = 1'b0;
    modelDir      = '0;

    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("reset");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] vector-only pair");
    applyStimulus(18'h04000, 18'h04000, 1'b1, 0, -1, -1);

    $display("[TB] vector plus three rotations");
    applyStimulus(BITWIDTH'($urandom), BITWIDTH'($urandom), 1'b0, 0, -1, -1);
    applyStimulus(BITWIDTH'($urandom), BITWIDTH'($urandom), 1'b0, 10, -1, -1);
    applyStimulus(BITWIDTH'($urandom), BITWIDTH'($urandom), 1'b0, 0, 4, -1);
    applyStimulus(BITWIDTH'($urandom), BITWIDTH'($urandom), 1'b1, 0, -1, -1);

    $display("[TB] spurious finish while idle");
    for (int k = 0; k < 3; k++) begin
      cor_finish_i = 1'b1;
      cor_x_i      = BITWIDTH'($urandom);
      @(posedge clk); #1;
      checkOutput($sformatf("idle finish valid %0d", k), 32'(bus.out_valid), 32'(0));
      checkOutput($sformatf("idle finish busy %0d", k), 32'(busy), 32'(0));
    end
    cor_finish_i = 1'b0;

    $display("[TB] reset during a rotate pair");
    applyStimulus(BITWIDTH'($urandom), BITWIDTH'($urandom), 1'b0, 0, -1, -1);
    applyStimulus(BITWIDTH'($urandom), BITWIDTH'($urandom), 1'b0, 0, -1, 7);

    $display("[TB] single-pair jobs back to back");
    applyStimulus(BITWIDTH'($urandom), BITWIDTH'($urandom), 1'b1, 0, -1, -1);
    applyStimulus(BITWIDTH'($urandom), BITWIDTH'($urandom), 1'b1, 1, -1, -1);

    $display("[TB] random jobs");
    for (int j = 0; j < 4; j++) begin
      len = int'($urandom_range(1, 3));
      for (int p = 0; p < len; p++) begin
        applyStimulus(BITWIDTH'($urandom), BITWIDTH'($urandom), (p == len - 1),
                      int'($urandom_range(0, 3)), -1, -1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
